// File: rtl/corepwm_tach_gen.sv
// corepwm_tach_gen: tachometer pulse generator for fan emulation and loopback
// self-test. Produces a pulse train on TACHOUT whose leading-edge spacing is
// per_s ticks and whose active width is high_s ticks of tach_cnt_clk.
// Continuous and burst modes are supported. PERIOD/HIGHDUR updates are
// deferred to a period boundary so a pulse is never cut short or stretched.
module corepwm_tach_gen #(
  parameter int PW = 16,
  parameter int BW = 8
) (
  input  logic          PCLK,
  input  logic          PRESETN,
  input  logic          tach_cnt_clk,
  input  logic          TACHGEN_EN,
  input  logic          TACHGEN_MODE,
  input  logic          TACH_EDGE,
  input  logic [PW-1:0] PERIOD,
  input  logic [PW-1:0] HIGHDUR,
  input  logic [BW-1:0] BURSTCNT,
  input  logic          load,
  output logic          TACHOUT,
  output logic          busy,
  output logic          done,
  output logic [PW-1:0] PULSECNT
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_INACTIVE = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] cnt_reg, cnt_next;
  logic [PW-1:0] per_s_reg, per_s_next;
  logic [PW-1:0] high_s_reg, high_s_next;
  logic [PW-1:0] pulse_reg, pulse_next;
  logic [BW-1:0] burst_reg, burst_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          upd_pend_reg, upd_pend_next;

  // Clamped candidate shadow values: period of at least 2 ticks, active
  // width of at least 1 tick, and always at least 1 inactive tick.
  logic [PW-1:0] per_clamp;
  logic [PW-1:0] high_min1;
  logic [PW-1:0] high_clamp;

  assign per_clamp  = (PERIOD < PW'(2)) ? PW'(2) : PERIOD;
  assign high_min1  = (HIGHDUR == '0) ? PW'(1) : HIGHDUR;
  assign high_clamp = (high_min1 > (per_clamp - PW'(1))) ? (per_clamp - PW'(1)) : high_min1;

  logic [PW-1:0] cnt_inc;
  logic [BW-1:0] burst_inc;
  logic          boundary;

  assign cnt_inc   = cnt_reg + PW'(1);
  // BW-bit wrap makes BURSTCNT == 0 naturally mean 2^BW pulses.
  assign burst_inc = burst_reg + BW'(1);
  assign boundary  = (cnt_reg == (per_s_reg - PW'(1)));

  // State and datapath registers, reset to idle with default shadows.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      per_s_reg    <= PW'(2);
      high_s_reg   <= PW'(1);
      pulse_reg    <= '0;
      burst_reg    <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      upd_pend_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      per_s_reg    <= per_s_next;
      high_s_reg   <= high_s_next;
      pulse_reg    <= pulse_next;
      burst_reg    <= burst_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      upd_pend_reg <= upd_pend_next;
    end
  end

  // Next-state logic: everything advances only on tick cycles, except that
  // a load strobe is remembered on any cycle until the next boundary.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    per_s_next    = per_s_reg;
    high_s_next   = high_s_reg;
    pulse_next    = pulse_reg;
    burst_next    = burst_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    upd_pend_next = upd_pend_reg | load;

    case (state_reg)
      ST_IDLE: begin
        if (tach_cnt_clk && TACHGEN_EN) begin
          per_s_next    = per_clamp;
          high_s_next   = high_clamp;
          cnt_next      = '0;
          pulse_next    = '0;
          burst_next    = '0;
          busy_next     = 1'b1;
          upd_pend_next = 1'b0;
          state_next    = ST_ACTIVE;
        end
      end

      ST_ACTIVE, ST_INACTIVE: begin
        if (tach_cnt_clk) begin
          if (boundary) begin
            cnt_next   = '0;
            pulse_next = pulse_reg + PW'(1);
            burst_next = burst_inc;
            if (TACHGEN_MODE && (burst_inc == BURSTCNT)) begin
              done_next  = 1'b1;
              busy_next  = 1'b0;
              state_next = ST_IDLE;
            end else if (!TACHGEN_EN) begin
              busy_next  = 1'b0;
              state_next = ST_IDLE;
            end else begin
              // A load on this very cycle counts as pending too.
              if (upd_pend_reg || load) begin
                per_s_next    = per_clamp;
                high_s_next   = high_clamp;
                upd_pend_next = 1'b0;
              end
              state_next = ST_ACTIVE;
            end
          end else begin
            cnt_next = cnt_inc;
            if (cnt_inc == high_s_reg) begin
              state_next = ST_INACTIVE;
            end
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // The active phase is held in state_reg; the level is mapped through
  // TACH_EDGE so idle (and reset) shows the inactive level and polarity
  // follows TACH_EDGE without waiting for a tick.
  assign TACHOUT  = (state_reg == ST_ACTIVE) ? TACH_EDGE : ~TACH_EDGE;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign PULSECNT = pulse_reg;

endmodule

// File: tb/tb_corepwm_tach_gen.sv
// Directed testbench for corepwm_tach_gen: reset, continuous, burst,
// clamping, deferred update, polarity and leading-edge spacing checks.
module tb_corepwm_tach_gen;

  localparam int PW = 16;
  localparam int BW = 8;

  logic          PCLK;
  logic          PRESETN;
  logic          tach_cnt_clk;
  logic          TACHGEN_EN;
  logic          TACHGEN_MODE;
  logic          TACH_EDGE;
  logic [PW-1:0] PERIOD;
  logic [PW-1:0] HIGHDUR;
  logic [BW-1:0] BURSTCNT;
  logic          load;
  logic          TACHOUT;
  logic          busy;
  logic          done;
  logic [PW-1:0] PULSECNT;

  int n_cmp = 0;
  int n_err = 0;

  int cyc = 0;
  int ph = 0;
  int div = 1;

  int   lead_cyc [0:15];
  int   nlead = 0;
  int   act = 0;
  int   ndone = 0;
  logic prev_out = 1'b0;

  corepwm_tach_gen #(.PW(PW), .BW(BW)) dut (
    .PCLK         (PCLK),
    .PRESETN      (PRESETN),
    .tach_cnt_clk (tach_cnt_clk),
    .TACHGEN_EN   (TACHGEN_EN),
    .TACHGEN_MODE (TACHGEN_MODE),
    .TACH_EDGE    (TACH_EDGE),
    .PERIOD       (PERIOD),
    .HIGHDUR      (HIGHDUR),
    .BURSTCNT     (BURSTCNT),
    .load         (load),
    .TACHOUT      (TACHOUT),
    .busy         (busy),
    .done         (done),
    .PULSECNT     (PULSECNT)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic mon_clear();
    nlead    = 0;
    act      = 0;
    ndone    = 0;
    prev_out = TACHOUT;
  endtask

  // One PCLK cycle: present the tick for this edge, sample 1 ns after it,
  // and record leading edges / active cycles / done pulses.
  task automatic step();
    tach_cnt_clk = (ph == 0);
    ph = (ph + 1 >= div) ? 0 : ph + 1;
    @(posedge PCLK);
    #1;
    cyc++;
    if ((TACHOUT === TACH_EDGE) && (prev_out !== TACH_EDGE)) begin
      if (nlead < 16) lead_cyc[nlead] = cyc;
      nlead++;
    end
    if (TACHOUT === TACH_EDGE) act++;
    if (done === 1'b1) ndone++;
    prev_out = TACHOUT;
    $display("cyc=%0d tick=%0b en=%0b out=%0b busy=%0b done=%0b pcnt=%0d",
             cyc, tach_cnt_clk, TACHGEN_EN, TACHOUT, busy, done, PULSECNT);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    PRESETN      = 1'b0;
    tach_cnt_clk = 1'b0;
    TACHGEN_EN   = 1'b0;
    TACHGEN_MODE = 1'b0;
    TACH_EDGE    = 1'b1;
    PERIOD       = 16'd10;
    HIGHDUR      = 16'd3;
    BURSTCNT     = 8'd4;
    load         = 1'b0;

    // ---- reset state ----
    #1;
    chk("rst_out", TACHOUT, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pcnt", PULSECNT, 0);
    run(2);
    PRESETN = 1'b1;
    run(3);
    chk("idle_out", TACHOUT, 0);
    chk("idle_busy", busy, 0);

    // ---- continuous: 10/3, tick every cycle ----
    div = 1; ph = 0;
    mon_clear();
    TACHGEN_EN = 1'b1;
    step();                                   // E0 start
    chk("cont_e0_out", TACHOUT, 1);
    chk("cont_e0_busy", busy, 1);
    chk("cont_e0_pcnt", PULSECNT, 0);
    run(2);                                   // E2
    chk("cont_e2_out", TACHOUT, 1);
    run(1);                                   // E3
    chk("cont_e3_out", TACHOUT, 0);
    run(7);                                   // E10 boundary
    chk("cont_e10_out", TACHOUT, 1);
    chk("cont_e10_pcnt", PULSECNT, 1);
    run(35);                                  // E45, mid period 5
    TACHGEN_EN = 1'b0;
    run(4);                                   // E49
    chk("cont_e49_busy", busy, 1);
    run(1);                                   // E50 final boundary
    chk("cont_stop_busy", busy, 0);
    chk("cont_stop_pcnt", PULSECNT, 5);
    chk("cont_stop_out", TACHOUT, 0);
    chk("cont_nlead", nlead, 5);
    chk("cont_space1", lead_cyc[1] - lead_cyc[0], 10);
    chk("cont_space4", lead_cyc[4] - lead_cyc[0], 40);
    chk("cont_active", act, 15);

    // ---- burst: 4 pulses of 6/2, tick every 4th PCLK ----
    TACHGEN_MODE = 1'b1;
    BURSTCNT     = 8'd4;
    PERIOD       = 16'd6;
    HIGHDUR      = 16'd2;
    div = 4; ph = 0;
    mon_clear();
    TACHGEN_EN = 1'b1;
    step();                                   // PCLK 0 start
    chk("bur_start_out", TACHOUT, 1);
    chk("bur_start_busy", busy, 1);
    run(95);                                  // PCLK 95
    chk("bur_95_busy", busy, 1);
    chk("bur_95_done", done, 0);
    run(1);                                   // PCLK 96 last boundary
    TACHGEN_EN = 1'b0;
    chk("bur_end_done", done, 1);
    chk("bur_end_busy", busy, 0);
    chk("bur_end_pcnt", PULSECNT, 4);
    chk("bur_end_out", TACHOUT, 0);
    run(1);
    chk("bur_done_clr", done, 0);
    chk("bur_nlead", nlead, 4);
    chk("bur_space1", lead_cyc[1] - lead_cyc[0], 24);
    chk("bur_space3", lead_cyc[3] - lead_cyc[0], 72);
    chk("bur_active", act, 32);
    chk("bur_ndone", ndone, 1);

    // ---- clamping: 0/0 -> 2/1 ----
    TACHGEN_MODE = 1'b0;
    PERIOD  = 16'd0;
    HIGHDUR = 16'd0;
    div = 1; ph = 0;
    TACHGEN_EN = 1'b1;
    step();                                   // E0
    chk("clp0_e0", TACHOUT, 1);
    step();                                   // E1
    chk("clp0_e1", TACHOUT, 0);
    step();                                   // E2 boundary
    chk("clp0_e2", TACHOUT, 1);
    chk("clp0_pcnt", PULSECNT, 1);
    TACHGEN_EN = 1'b0;
    run(2);                                   // E4 boundary -> idle
    chk("clp0_stop", busy, 0);

    // ---- clamping: 5/9 -> high 4, low 1 ----
    PERIOD  = 16'd5;
    HIGHDUR = 16'd9;
    TACHGEN_EN = 1'b1;
    step();                                   // E0
    chk("clp5_e0", TACHOUT, 1);
    run(3);                                   // E3
    chk("clp5_e3", TACHOUT, 1);
    run(1);                                   // E4
    chk("clp5_e4", TACHOUT, 0);
    run(1);                                   // E5 boundary
    chk("clp5_e5", TACHOUT, 1);
    TACHGEN_EN = 1'b0;
    run(5);                                   // E10 boundary -> idle
    chk("clp5_stop", busy, 0);

    // ---- deferred update: 8/4, load 12/6 mid period ----
    PERIOD  = 16'd8;
    HIGHDUR = 16'd4;
    TACHGEN_EN = 1'b1;
    step();                                   // E0
    run(2);                                   // E2 (cnt 2)
    PERIOD  = 16'd12;
    HIGHDUR = 16'd6;
    load    = 1'b1;
    step();                                   // E3
    load    = 1'b0;
    chk("upd_e3", TACHOUT, 1);
    step();                                   // E4: old high 4 still in force
    chk("upd_e4", TACHOUT, 0);
    run(4);                                   // E8 boundary, new 12/6
    chk("upd_e8", TACHOUT, 1);
    chk("upd_e8_pcnt", PULSECNT, 1);
    run(5);                                   // E13
    chk("upd_e13", TACHOUT, 1);
    step();                                   // E14
    chk("upd_e14", TACHOUT, 0);
    run(5);                                   // E19
    chk("upd_e19", TACHOUT, 0);
    step();                                   // E20 boundary
    chk("upd_e20", TACHOUT, 1);
    chk("upd_e20_pcnt", PULSECNT, 2);
    run(11);                                  // E31
    PERIOD  = 16'd4;
    HIGHDUR = 16'd1;
    load    = 1'b1;
    step();                                   // E32 boundary with load
    load    = 1'b0;
    chk("updb_e32", TACHOUT, 1);
    step();                                   // E33: high is 1 now
    chk("updb_e33", TACHOUT, 0);
    run(3);                                   // E36 boundary
    chk("updb_e36", TACHOUT, 1);
    chk("updb_pcnt", PULSECNT, 4);
    TACHGEN_EN = 1'b0;
    run(4);                                   // E40 -> idle
    chk("updb_stop", busy, 0);
    chk("updb_stop_pcnt", PULSECNT, 5);

    // ---- polarity and loopback spacing ----
    TACH_EDGE = 1'b0;
    PERIOD    = 16'd100;
    HIGHDUR   = 16'd50;
    #1;
    chk("pol_idle_high", TACHOUT, 1);
    mon_clear();
    TACHGEN_EN = 1'b1;
    step();                                   // E0 falling leading edge
    chk("pol_e0", TACHOUT, 0);
    run(50);                                  // E50
    chk("pol_e50", TACHOUT, 1);
    run(50);                                  // E100
    chk("pol_e100", TACHOUT, 0);
    chk("pol_measure", lead_cyc[1] - lead_cyc[0], 100);
    TACHGEN_EN = 1'b0;
    run(100);                                 // E200 -> idle
    chk("pol_stop_busy", busy, 0);
    chk("pol_stop_out", TACHOUT, 1);

    // ---- asynchronous reset mid-run ----
    TACH_EDGE = 1'b1;
    PERIOD    = 16'd10;
    HIGHDUR   = 16'd3;
    TACHGEN_EN = 1'b1;
    step();                                   // E0
    run(14);                                  // E14
    chk("mid_pre_pcnt", PULSECNT, 1);
    #2;
    PRESETN = 1'b0;
    #1;
    chk("mid_rst_out", TACHOUT, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_pcnt", PULSECNT, 0);
    TACHGEN_EN = 1'b0;
    run(2);
    PRESETN = 1'b1;
    run(3);
    chk("mid_post_out", TACHOUT, 0);
    chk("mid_post_busy", busy, 0);
    TACHGEN_EN = 1'b1;
    step();
    chk("mid_restart_out", TACHOUT, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
